// File: rtl/cluster_counter_pkg.sv
// Shared definitions for the cluster counter and the adjacency-join stage it follows.
// Holds the default column count, the scan FSM encoding and the frame header constant.
package cluster_counter_pkg;

  localparam int N_COL_DEF = 38;

  localparam logic [15:0] FRAME_HEADER = 16'hAAAA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cluster_col_step.sv
// One column of the 2-row cluster scan: given this column's cells and the previous
// column's run flags, returns the cluster-count delta, hit delta and next shared flag.
module cluster_col_step (
  input  logic              t_i,
  input  logic              b_i,
  input  logic              pt_i,
  input  logic              pb_i,
  input  logic              ps_i,
  output logic signed [1:0] clus_delta_o,
  output logic        [1:0] hit_delta_o,
  output logic              ps_next_o
);

  always_comb begin
    clus_delta_o = 2'sd0;
    ps_next_o    = 1'b0;
    unique case ({t_i, b_i})
      2'b11: begin
        if (!pt_i && !pb_i) begin
          clus_delta_o = 2'sd1;
        end else if (pt_i && pb_i && !ps_i) begin
          clus_delta_o = -2'sd1;
        end
        ps_next_o = 1'b1;
      end
      2'b10: begin
        if (!pt_i) clus_delta_o = 2'sd1;
      end
      2'b01: begin
        if (!pb_i) clus_delta_o = 2'sd1;
      end
      default: begin
        clus_delta_o = 2'sd0;
      end
    endcase
  end

  assign hit_delta_o = {1'b0, t_i} + {1'b0, b_i};

endmodule

// File: rtl/cluster_counter.sv
// Counts 4-connected clusters and hit cells over a captured 2 x N_COL frame, scanning
// one column per clock, and flags a trigger when the cluster count reaches the threshold.
module cluster_counter
  import cluster_counter_pkg::*;
#(
  parameter int N_COL = N_COL_DEF,
  parameter int CNT_W = 6,
  parameter int HIT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N_COL-1:0] array_in0,
  input  logic [N_COL-1:0] array_in1,
  input  logic [CNT_W-1:0] clus_thresh,
  input  logic             err_clr,
  output logic             busy,
  output logic             out_valid,
  output logic [CNT_W-1:0] clus_count,
  output logic [HIT_W-1:0] hit_count,
  output logic             trig,
  output logic             drop_err
);

  localparam int               COL_W    = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COL - 1);

  state_e           state_q;
  logic [N_COL-1:0] row0_q;
  logic [N_COL-1:0] row1_q;
  logic [CNT_W-1:0] thresh_q;
  logic [COL_W-1:0] col_q;
  logic             pt_q;
  logic             pb_q;
  logic             ps_q;
  logic [CNT_W-1:0] clus_acc_q;
  logic [HIT_W-1:0] hit_acc_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] clus_count_q;
  logic [HIT_W-1:0] hit_count_q;
  logic             trig_q;
  logic             drop_err_q;

  logic              t_col;
  logic              b_col;
  logic signed [1:0] clus_delta;
  logic        [1:0] hit_delta;
  logic              ps_d;
  logic [CNT_W-1:0]  clus_acc_d;
  logic [HIT_W-1:0]  hit_acc_d;
  logic              accept;
  logic              drop;

  assign t_col = row0_q[col_q];
  assign b_col = row1_q[col_q];

  cluster_col_step u_step (
    .t_i          (t_col),
    .b_i          (b_col),
    .pt_i         (pt_q),
    .pb_i         (pb_q),
    .ps_i         (ps_q),
    .clus_delta_o (clus_delta),
    .hit_delta_o  (hit_delta),
    .ps_next_o    (ps_d)
  );

  // Delta is sign-extended so a merge decrements the unsigned accumulator.
  assign clus_acc_d = clus_acc_q + {{(CNT_W-2){clus_delta[1]}}, clus_delta};
  assign hit_acc_d  = hit_acc_q + {{(HIT_W-2){1'b0}}, hit_delta};

  assign accept = in_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign drop   = in_valid && (state_q == ST_SCAN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      row0_q       <= '0;
      row1_q       <= '0;
      thresh_q     <= '0;
      col_q        <= '0;
      pt_q         <= 1'b0;
      pb_q         <= 1'b0;
      ps_q         <= 1'b0;
      clus_acc_q   <= '0;
      hit_acc_q    <= '0;
      out_valid_q  <= 1'b0;
      clus_count_q <= '0;
      hit_count_q  <= '0;
      trig_q       <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;

      if (drop) begin
        drop_err_q <= 1'b1;
      end else if (err_clr) begin
        drop_err_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_q == ST_DONE) begin
            clus_count_q <= clus_acc_q;
            hit_count_q  <= hit_acc_q;
            trig_q       <= (clus_acc_q >= thresh_q);
            out_valid_q  <= 1'b1;
          end
          // DONE accepts a new frame exactly like IDLE, giving back-to-back frames.
          if (accept) begin
            row0_q     <= array_in0;
            row1_q     <= array_in1;
            thresh_q   <= clus_thresh;
            clus_acc_q <= '0;
            hit_acc_q  <= '0;
            col_q      <= '0;
            pt_q       <= 1'b0;
            pb_q       <= 1'b0;
            ps_q       <= 1'b0;
            state_q    <= ST_SCAN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          clus_acc_q <= clus_acc_d;
          hit_acc_q  <= hit_acc_d;
          pt_q       <= t_col;
          pb_q       <= b_col;
          ps_q       <= ps_d;
          if (col_q == LAST_COL) begin
            state_q <= ST_DONE;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q == ST_SCAN);
  assign out_valid  = out_valid_q;
  assign clus_count = clus_count_q;
  assign hit_count  = hit_count_q;
  assign trig       = trig_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_cluster_counter.sv
// Scoreboard bench for cluster_counter: frames are scored by a flood-fill reference
// model at issue time, and a monitor pops and compares whenever out_valid pulses.
module tb_cluster_counter;

  localparam int N   = cluster_counter_pkg::N_COL_DEF;
  localparam int CW  = 6;
  localparam int HW  = 7;
  localparam int LAT = N + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic [N-1:0]  array_in0 = '0;
  logic [N-1:0]  array_in1 = '0;
  logic [CW-1:0] clus_thresh = '0;
  logic          busy;
  logic          out_valid;
  logic [CW-1:0] clus_count;
  logic [HW-1:0] hit_count;
  logic          trig;
  logic          drop_err;

  typedef struct {
    int clus;
    int hit;
    bit trig;
    int dueEdge;
  } exp_t;

  exp_t sb[$];
  exp_t lastExp = '{0, 0, 1'b0, 0};
  exp_t monE;
  int   checks = 0;
  int   failures = 0;
  int   edgeCount = 0;
  bit   haveAccept = 1'b0;
  int   lastAccept = 0;
  bit   expDropErr = 1'b0;

  cluster_counter #(.N_COL(N), .CNT_W(CW), .HIT_W(HW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .array_in0   (array_in0),
    .array_in1   (array_in1),
    .clus_thresh (clus_thresh),
    .err_clr     (err_clr),
    .busy        (busy),
    .out_valid   (out_valid),
    .clus_count  (clus_count),
    .hit_count   (hit_count),
    .trig        (trig),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, expv, edgeCount);
    end
  endtask

  // Connected components by repeated min-label relaxation over the 2 x N grid.
  function automatic void refModel(input logic [N-1:0] r0, input logic [N-1:0] r1,
                                   output int clus, output int hit);
    int lab [2][N];
    bit changed;
    int m;
    clus = 0;
    hit  = 0;
    for (int c = 0; c < N; c++) begin
      lab[0][c] = r0[c] ? (c + 1) : 0;
      lab[1][c] = r1[c] ? (N + c + 1) : 0;
      hit += int'(r0[c]) + int'(r1[c]);
    end
    do begin
      changed = 1'b0;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < N; c++) begin
          if (lab[r][c] != 0) begin
            m = lab[r][c];
            if (c > 0 && lab[r][c-1] != 0 && lab[r][c-1] < m) m = lab[r][c-1];
            if (c < N - 1 && lab[r][c+1] != 0 && lab[r][c+1] < m) m = lab[r][c+1];
            if (lab[1-r][c] != 0 && lab[1-r][c] < m) m = lab[1-r][c];
            if (m != lab[r][c]) begin
              lab[r][c] = m;
              changed = 1'b1;
            end
          end
        end
      end
    end while (changed);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++)
        if (lab[r][c] == r * N + c + 1) clus++;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one in_valid strobe and predicts whether the DUT accepts or drops it.
  task automatic applyStimulus(input logic [N-1:0] r0, input logic [N-1:0] r1,
                               input logic [CW-1:0] th, input bit clr);
    int   c;
    int   h;
    exp_t e;
    logic [63:0] junk;
    array_in0   = r0;
    array_in1   = r1;
    clus_thresh = th;
    in_valid    = 1'b1;
    err_clr     = clr;
    tick();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    junk = {$urandom(), $urandom()};
    array_in0 = junk[N-1:0];
    array_in1 = ~junk[N-1:0];
    clus_thresh = CW'($urandom_range(0, 63));
    if (!haveAccept || (edgeCount - lastAccept) >= LAT) begin
      refModel(r0, r1, c, h);
      e.clus    = c;
      e.hit     = h;
      e.trig    = (c >= int'(th));
      e.dueEdge = edgeCount + LAT;
      sb.push_back(e);
      haveAccept = 1'b1;
      lastAccept = edgeCount;
      if (clr) expDropErr = 1'b0;
    end else begin
      expDropErr = 1'b1;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 4 * LAT) begin
      tick();
      n++;
    end
    checkOutput("pending_results", longint'(sb.size()), 0);
    sb.delete();
    tick();
    tick();
    checkOutput("held_clus_count", longint'(clus_count), lastExp.clus);
    checkOutput("held_hit_count", longint'(hit_count), lastExp.hit);
    checkOutput("held_trig", longint'(trig), longint'(lastExp.trig));
    checkOutput("out_valid_single_pulse", longint'(out_valid), 0);
  endtask

  task automatic clearErr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expDropErr = 1'b0;
    checkOutput("drop_err_cleared", longint'(drop_err), 0);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out_valid actual=1 expected=0 (edge %0d)", edgeCount);
      end else begin
        monE = sb.pop_front();
        checkOutput("latency_edge", edgeCount, monE.dueEdge);
        checkOutput("clus_count", longint'(clus_count), monE.clus);
        checkOutput("hit_count", longint'(hit_count), monE.hit);
        checkOutput("trig", longint'(trig), longint'(monE.trig));
        lastExp = monE;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rnd0;
    logic [63:0] rnd1;
    logic [N-1:0] r0;
    logic [N-1:0] r1;
    int gap;
    int mode;

    $display("[TB] start");
    repeat (3) tick();
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_clus_count", longint'(clus_count), 0);
    checkOutput("reset_hit_count", longint'(hit_count), 0);
    checkOutput("reset_trig", longint'(trig), 0);
    checkOutput("reset_drop_err", longint'(drop_err), 0);
    rst = 1'b1;

    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("idle_busy", longint'(busy), 0);
      checkOutput("idle_out_valid", longint'(out_valid), 0);
    end

    $display("[TB] directed frames");
    applyStimulus('0, '0, 6'd1, 1'b0);
    checkOutput("busy_after_accept", longint'(busy), 1);
    waitDrain();
    applyStimulus(38'h00_0000_000E, 38'h00_0000_0C00, 6'd2, 1'b0);
    waitDrain();
    applyStimulus(38'h00_0000_001C, 38'h00_0000_0014, 6'd2, 1'b0);
    waitDrain();
    applyStimulus(38'h00_0000_0014, 38'h00_0000_001C, 6'd1, 1'b0);
    waitDrain();
    applyStimulus(38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 6'd1, 1'b0);
    waitDrain();
    applyStimulus(38'h15_5555_5555, 38'h2A_AAAA_AAAA, 6'd38, 1'b0);
    waitDrain();

    $display("[TB] drop and error clear");
    applyStimulus(38'h00_0F00_00F0, 38'h00_00F0_0F00, 6'd3, 1'b0);
    repeat (9) tick();
    applyStimulus(38'h3F_FFFF_FFFF, 38'h00_0000_0000, 6'd0, 1'b0);
    checkOutput("busy_during_scan", longint'(busy), 1);
    waitDrain();
    checkOutput("drop_err_set", longint'(drop_err), longint'(expDropErr));
    clearErr();
    applyStimulus(38'h00_0000_0003, 38'h00_0000_0000, 6'd1, 1'b0);
    repeat (5) tick();
    applyStimulus(38'h00_0000_0000, 38'h00_0000_0001, 6'd1, 1'b1);
    waitDrain();
    checkOutput("drop_beats_clear", longint'(drop_err), longint'(expDropErr));
    clearErr();

    $display("[TB] back-to-back");
    applyStimulus(38'h01_2345_6789, 38'h0A_BCDE_F012, 6'd5, 1'b0);
    repeat (LAT - 1) tick();
    applyStimulus(38'h30_0000_0003, 38'h00_0F00_0000, 6'd4, 1'b0);
    waitDrain();
    checkOutput("b2b_no_drop", longint'(drop_err), 0);

    $display("[TB] reset mid-scan");
    applyStimulus(38'h2A_AAAA_AAAA, 38'h15_5555_5555, 6'd2, 1'b0);
    repeat (20) tick();
    rst = 1'b0;
    sb.delete();
    haveAccept = 1'b0;
    expDropErr = 1'b0;
    lastExp = '{0, 0, 1'b0, 0};
    #1;
    checkOutput("abort_busy", longint'(busy), 0);
    checkOutput("abort_clus_count", longint'(clus_count), 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (LAT + 5) tick();
    checkOutput("abort_no_result_busy", longint'(busy), 0);
    checkOutput("abort_no_result_clus", longint'(clus_count), 0);
    applyStimulus(38'h2A_AAAA_AAAA, 38'h00_0000_0000, 6'd19, 1'b0);
    waitDrain();

    $display("[TB] random frames");
    for (int i = 0; i < 40; i++) begin
      rnd0 = {$urandom(), $urandom()};
      rnd1 = {$urandom(), $urandom()};
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin r0 = rnd0[N-1:0]; r1 = rnd1[N-1:0]; end
        1: begin r0 = rnd0[N-1:0] & rnd1[N-1:0]; r1 = rnd0[N+9:10] & rnd1[N+19:20]; end
        2: begin r0 = rnd0[N-1:0] | rnd1[N-1:0]; r1 = rnd0[N+9:10] | rnd1[N+19:20]; end
        default: begin r0 = rnd0[N-1:0] & rnd1[N+9:10]; r1 = ~r0 & rnd1[N-1:0]; end
      endcase
      applyStimulus(r0, r1, CW'($urandom_range(0, 25)), 1'b0);
      mode = $urandom_range(0, 9);
      if (mode < 2) gap = $urandom_range(1, LAT - 2);
      else if (mode < 5) gap = LAT - 1;
      else gap = LAT - 1 + $urandom_range(1, 6);
      repeat (gap) tick();
    end
    waitDrain();
    checkOutput("random_drop_err", longint'(drop_err), longint'(expDropErr));
    clearErr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
